// File: rtl/ilim_dac_pkg.sv
// Shared definitions for the ILIM DAC sequencer.
//   - OPB register map constants
//   - sequencer FSM state type
//   - channel code loaded at reset (DAC mid-scale)
package ilim_dac_pkg;

  localparam logic [3:0] ADDR_CHAN0   = 4'h0;
  localparam logic [3:0] ADDR_CHAN7   = 4'h7;
  localparam logic [3:0] ADDR_CTRL    = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'h9;
  localparam logic [3:0] ADDR_UPD_CNT = 4'hA;

  localparam logic [7:0] CHAN_RST_CODE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETUP,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/ilim_dac_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into the
// local clock domain.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, output clears to 0
//   d_i    : asynchronous input level
//   q_o    : synchronised level (2-3 cycle latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ilim_dac_sequencer.sv
// ILIM DAC sequencer: holds 8 shadow channel codes written over OPB, tracks
// which ones changed and feeds them one at a time to the AD8803 serializer
// through its trig/done handshake.
//   OPB_CLK, OPB_RST_N      : clock, asynchronous active-low reset
//   OPB_ADDR/DI/WE/RE/DO    : register port (CHAN0-7, CTRL, STATUS, UPD_CNT)
//   DAC_TRIG/DATA/ADDR      : request to serializer, data/addr held from
//                             channel selection until the next selection
//   DAC_DONE                : serializer done, foreign clock domain
//   BUSY                    : high whenever a transfer is in progress
module ilim_dac_sequencer
  import ilim_dac_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic [3:0]  OPB_ADDR,
  input  logic [15:0] OPB_DI,
  input  logic        OPB_WE,
  input  logic        OPB_RE,
  output logic [31:0] OPB_DO,
  output logic        DAC_TRIG,
  output logic [7:0]  DAC_DATA,
  output logic [2:0]  DAC_ADDR,
  input  logic        DAC_DONE,
  output logic        BUSY
);

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  chan_q [8];
  logic [7:0]  chan_d [8];
  logic [7:0]  dirty_q, dirty_d;
  logic        enable_q, enable_d;
  logic        err_q, err_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] upd_cnt_q, upd_cnt_d;
  logic        trig_q, trig_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  addr_q, addr_d;

  logic        done_s;
  logic [2:0]  sel_ch;
  logic [2:0]  chan_idx;
  logic        chan_hit;
  logic [31:0] rdata;
  logic        unused_di;

  // First set bit of mask at or above ptr, wrapping 7->0. Scans offsets from
  // high to low so the smallest offset is the last (winning) assignment.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                         input logic [2:0] ptr);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = ptr;
    for (int unsigned k = 8; k > 0; k--) begin
      idx = ptr + 3'(k - 1);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

  sync_2ff u_done_sync (
    .clk_i  (OPB_CLK),
    .rst_ni (OPB_RST_N),
    .d_i    (DAC_DONE),
    .q_o    (done_s)
  );

  assign chan_idx  = 3'(OPB_ADDR - ADDR_CHAN0);
  assign chan_hit  = (OPB_ADDR <= ADDR_CHAN7);
  assign sel_ch    = rr_pick(dirty_q, rr_ptr_q);
  assign unused_di = ^OPB_DI[15:8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    chan_d    = chan_q;
    dirty_d   = dirty_q;
    enable_d  = enable_q;
    err_d     = err_q;
    rr_ptr_d  = rr_ptr_q;
    upd_cnt_d = upd_cnt_q;
    trig_d    = trig_q;
    data_d    = data_q;
    addr_d    = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_q && (|dirty_q) && !done_s) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        addr_d          = sel_ch;
        data_d          = chan_q[sel_ch];
        dirty_d[sel_ch] = 1'b0;
        rr_ptr_d        = sel_ch + 3'd1;
        state_d         = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          trig_d  = 1'b1;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (done_s) begin
          trig_d    = 1'b0;
          upd_cnt_d = upd_cnt_q + 16'd1;
          state_d   = ST_WAIT_LO;
        end else if (cnt_q >= TMO_LAST) begin
          trig_d  = 1'b0;
          state_d = ST_ABORT;
        end
      end
      ST_WAIT_LO: begin
        if (!done_s) state_d = ST_IDLE;
        else if (cnt_q >= TMO_LAST) state_d = ST_ABORT;
      end
      ST_ABORT: begin
        trig_d          = 1'b0;
        err_d           = 1'b1;
        enable_d        = 1'b0;
        dirty_d[addr_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Register writes follow the FSM so a same-cycle dirty set beats the
    // SELECT clear; the abort's err/enable update still wins over software.
    if (OPB_WE) begin
      if (chan_hit) begin
        chan_d[chan_idx]  = OPB_DI[7:0];
        dirty_d[chan_idx] = 1'b1;
      end else if (OPB_ADDR == ADDR_CTRL) begin
        if (state_q != ST_ABORT) enable_d = OPB_DI[0];
        if (OPB_DI[1]) dirty_d = '1;
      end else if (OPB_ADDR == ADDR_STATUS) begin
        if (OPB_DI[1] && (state_q != ST_ABORT)) err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      chan_q    <= '{default: CHAN_RST_CODE};
      dirty_q   <= '0;
      enable_q  <= 1'b0;
      err_q     <= 1'b0;
      rr_ptr_q  <= '0;
      upd_cnt_q <= '0;
      trig_q    <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      dirty_q   <= dirty_d;
      enable_q  <= enable_d;
      err_q     <= err_d;
      rr_ptr_q  <= rr_ptr_d;
      upd_cnt_q <= upd_cnt_d;
      trig_q    <= trig_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (chan_hit) begin
      rdata[7:0] = chan_q[chan_idx];
    end else begin
      case (OPB_ADDR)
        ADDR_CTRL:    rdata[0] = enable_q;
        ADDR_STATUS: begin
          rdata[0]     = BUSY;
          rdata[1]     = err_q;
          rdata[10:8]  = addr_q;
          rdata[23:16] = dirty_q;
        end
        ADDR_UPD_CNT: rdata[15:0] = upd_cnt_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign OPB_DO   = OPB_RE ? rdata : 'z;
  assign DAC_TRIG = trig_q;
  assign DAC_DATA = data_q;
  assign DAC_ADDR = addr_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule
